// File: rtl/branch_pc_unit.sv
// Program counter with fetch increment, jump-register load and two-step
// conditional branch resolution that waits one cycle for the CON flag.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          OFFSET_W = 19
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                pc_inc,
    input  logic                jr_req,
    input  logic [31:0]         jr_target,
    input  logic                br_req,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic                con_out,
    output logic [31:0]         pc_out,
    output logic                busy,
    output logic                br_done,
    output logic                br_taken
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_CON = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic                  br_done_q, br_done_d;
    logic                  br_taken_q, br_taken_d;

    function automatic logic [31:0] sext_offset(input logic [OFFSET_W-1:0] off);
        return {{(32-OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

    // Next-state logic: one request per IDLE cycle, CON sampled in WAIT_CON
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        offset_d   = offset_q;
        br_done_d  = 1'b0;
        br_taken_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (jr_req) begin
                    pc_d = jr_target;
                end else if (br_req) begin
                    offset_d = br_offset;
                    state_d  = WAIT_CON;
                end else if (pc_inc) begin
                    pc_d = pc_q + 32'd1;
                end else begin
                    pc_d = pc_q;
                end
            end
            WAIT_CON: begin
                state_d   = IDLE;
                br_done_d = 1'b1;
                // Offset is relative to the already-incremented fetch PC
                if (con_out) begin
                    pc_d       = pc_q + sext_offset(offset_q);
                    br_taken_d = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and status-pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            offset_q   <= {OFFSET_W{1'b0}};
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            offset_q   <= offset_d;
            br_done_q  <= br_done_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign pc_out   = pc_q;
    assign busy     = (state_q == WAIT_CON);
    assign br_done  = br_done_q;
    assign br_taken = br_taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard-driven bench for branch_pc_unit: each step pushes the expected
// {pc, busy, br_done, br_taken} and pops it one edge later for comparison.
module tb_branch_pc_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pc_inc;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        br_req;
    logic [18:0] br_offset;
    logic        con_out;
    logic [31:0] pc_out;
    logic        busy;
    logic        br_done;
    logic        br_taken;

    int n_checks = 0;
    int n_fails  = 0;

    logic [34:0] exp_q[$];
    logic [34:0] got;
    logic [34:0] exp_v;

    typedef struct {
        logic        inc;
        logic        jr;
        logic        br;
        logic        con;
        logic [31:0] tgt;
        logic [18:0] off;
        logic [34:0] exp;
    } step_t;

    branch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .OFFSET_W (19)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pc_inc    (pc_inc),
        .jr_req    (jr_req),
        .jr_target (jr_target),
        .br_req    (br_req),
        .br_offset (br_offset),
        .con_out   (con_out),
        .pc_out    (pc_out),
        .busy      (busy),
        .br_done   (br_done),
        .br_taken  (br_taken)
    );

    always #5 clock = ~clock;

    function automatic step_t st(input logic inc, input logic jr, input logic br,
                                 input logic con, input logic [31:0] tgt,
                                 input logic [18:0] off, input logic [31:0] pc,
                                 input logic b, input logic d, input logic t);
        step_t s;
        s.inc = inc; s.jr = jr; s.br = br; s.con = con;
        s.tgt = tgt; s.off = off;
        s.exp = {pc, b, d, t};
        return s;
    endfunction

    task automatic apply(input step_t s);
        pc_inc    = s.inc;
        jr_req    = s.jr;
        br_req    = s.br;
        con_out   = s.con;
        jr_target = s.tgt;
        br_offset = s.off;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pc_inc = 1'b1; jr_req = 1'b0; br_req = 1'b0; con_out = 1'b0;
        jr_target = 32'h0; br_offset = 19'h0;
        #12;
        exp_q.push_back({32'h0000_0000, 1'b0, 1'b0, 1'b0});
        got = {pc_out, busy, br_done, br_taken};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fails++;
            $display("FAIL reset_hold: got %h expected %h", got, exp_v);
        end
        pc_inc = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        exp_q.push_back({32'h0000_0000, 1'b0, 1'b0, 1'b0});
        got = {pc_out, busy, br_done, br_taken};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fails++;
            $display("FAIL reset_release: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_pc_inc();
        step_t s[$];
        s.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h1, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h2, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h3, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h3, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL pc_inc step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_branch_fwd();
        step_t s[$];
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 19'h0, 32'h10, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h00005, 32'h10, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'h15, 1'b0, 1'b1, 1'b1));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h15, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL branch_fwd step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_branch_neg();
        step_t s[$];
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 19'h0, 32'h10, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h7FFFF, 32'h10, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'h0F, 1'b0, 1'b1, 1'b1));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 19'h0, 32'h10, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h7FFFF, 32'h10, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h10, 1'b0, 1'b1, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h10, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL branch_neg step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_priority();
        step_t s[$];
        // All three requests at once: jump wins, no branch started
        s.push_back(st(1'b1, 1'b1, 1'b1, 1'b1, 32'hABCD, 19'h00003, 32'hABCD, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'hABCD, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 19'h00001, 32'hABCD, 1'b1, 1'b0, 1'b0));
        // Requests during WAIT_CON are dropped
        s.push_back(st(1'b1, 1'b1, 1'b1, 1'b0, 32'h5555, 19'h00007, 32'hABCD, 1'b0, 1'b1, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'hABCD, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL priority step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h00002, 32'hABCD, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'hABCF, 1'b0, 1'b1, 1'b1));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h00003, 32'hABCF, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'hABD2, 1'b0, 1'b1, 1'b1));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'hABD2, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL back_to_back step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_wrap();
        step_t s[$];
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 19'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 19'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 19'h0, 32'h0000_0002, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h7FFFC, 32'h0000_0002, 1'b1, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL wrap step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t s[$];
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 19'h0, 32'h40, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 19'h00008, 32'h40, 1'b1, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL async_reset_setup step %0d: got %h expected %h", i, got, exp_v);
            end
        end
        // Now in WAIT_CON; reset mid-cycle with a taken condition pending
        br_req = 1'b0;
        con_out = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back({32'h0000_0000, 1'b0, 1'b0, 1'b0});
        got = {pc_out, busy, br_done, br_taken};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_fails++;
            $display("FAIL async_reset_immediate: got %h expected %h", got, exp_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        s.delete();
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 19'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clock); #1;
            got = {pc_out, busy, br_done, br_taken};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_fails++;
                $display("FAIL async_reset_after step %0d: got pc=%h b/d/t=%b expected pc=%h b/d/t=%b",
                         i, got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pc_inc();
        test_branch_fwd();
        test_branch_neg();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter register with branch resolution, placed directly downstream of the CON flip-flop.
- Increments the PC on fetch, loads it from the bus for jump-register, and resolves conditional branches.
- For a branch, it waits one cycle for the CON flag to settle, then applies PC <= PC + sign-extended offset if the branch is taken.
- Reports busy, branch-done and branch-taken status to the control sequencer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- OFFSET_W, 19, width of the branch offset field (C field, IR[18:0]).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pc_inc  input  1  request PC <= PC + 1.
- jr_req  input  1  request PC <= jr_target.
- jr_target  input  32  jump target taken from the bus.
- br_req  input  1  start a conditional branch. Asserted in the same cycle the sequencer asserts conIn to the CON flip-flop.
- br_offset  input  OFFSET_W  signed branch displacement.
- con_out  input  1  condition result from the CON flip-flop; valid the cycle after conIn.
- pc_out  output  32  current PC.
- busy  output  1  high while in WAIT_CON.
- br_done  output  1  one-cycle pulse when a branch resolves.
- br_taken  output  1  one-cycle pulse, coincident with br_done, when the PC was redirected.

Behaviour:
- Reset (async, reset_n=0): pc_out=RESET_PC, state=IDLE, busy=0, br_done=0, br_taken=0, offset register cleared. Reset during WAIT_CON abandons the branch with no pulse.
- States: IDLE, WAIT_CON.
- In IDLE, request priority is jr_req > br_req > pc_inc. Exactly one request is honoured per cycle; the rest are dropped.
  - jr_req: pc_out <= jr_target next edge; stay IDLE.
  - br_req: latch br_offset into offset_q; go to WAIT_CON; pc_out unchanged.
  - pc_inc: pc_out <= pc_out + 1; stay IDLE.
  - No request: hold.
- WAIT_CON lasts exactly one cycle; busy=1 combinationally in this state.
  - Sample con_out at the edge.
  - If con_out=1: pc_out <= pc_out + sext(offset_q); br_taken=1 for the following cycle.
  - If con_out=0: pc_out unchanged.
  - In both cases br_done=1 for the following cycle; return to IDLE.
  - All requests (pc_inc, jr_req, br_req) are ignored in this state.
- Branch latency: br_req at edge N; resolve at edge N+1; pc_out and the pulses are visible after edge N+1. br_done/br_taken are registered and high for exactly one cycle.
- Arithmetic:
  - 32-bit, modulo 2^32; no overflow flag.
  - sext replicates offset_q[OFFSET_W-1] into the upper bits.
  - PC+1 from 32'hFFFF_FFFF wraps to 0.
  - Negative offsets wrap the same way.
- The offset is added to the PC already incremented by the preceding fetch. The block itself does not add 1 on a branch.
- A back-to-back br_req in the cycle after the resolve cycle (IDLE again) is honoured normally.
- pc_out is a register output; no combinational path from inputs to pc_out.

Test Plan:
- Reset then pc_inc for 3 cycles -> pc_out = 0,1,2,3; busy=0 throughout; release reset mid-cycle with no glitch on pc_out.
- PC=0x10, br_req with offset=0x00005, con_out=1 at next edge -> after resolve pc_out=0x15; br_done=br_taken=1 for one cycle, then 0.
- PC=0x10, br_req with offset=0x7FFFF (-1), con_out=1 -> pc_out=0x0F. Repeat with con_out=0 -> pc_out=0x10, br_done=1, br_taken=0.
- Same cycle jr_req (jr_target=0xABCD), br_req and pc_inc from IDLE -> pc_out=0xABCD, no WAIT_CON, no br_done. Then pc_inc/jr_req held during WAIT_CON -> ignored, busy=1 that cycle.
- Wrap cases: PC=0xFFFF_FFFF with pc_inc -> 0x0000_0000. PC=0x2 with offset -4 taken -> 0xFFFF_FFFE.
- Reset asserted asynchronously while in WAIT_CON -> immediate pc_out=RESET_PC, busy=0, no br_done pulse after release.
